// File: rtl/vr_vc_converter_pkg.sv
// vr_vc_converter_pkg: default constants and credit-counter width helper for vr_vc_converter.
package vr_vc_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CREDIT_NUM = 2;
  localparam int DEF_BUF_DEPTH  = 2;
  function automatic int cnt_width(input int credits);
    return $clog2(credits + 1);
  endfunction
endpackage

// File: rtl/vr_vc_converter_fifo.sv
// vr_vc_converter_fifo: small circular input buffer with occupancy count; caller never pushes when full or pops when empty.
module vr_vc_converter_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0] n_q, n_d;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wr_q] = data_i;
    wr_d = push_i ? inc(wr_q) : wr_q;
    rd_d = pop_i ? inc(rd_q) : rd_q;
    n_d  = n_q + NW'(push_i) - NW'(pop_i);
  end
  assign data_o  = mem_q[rd_q];
  assign full_o  = n_q == NW'(DEPTH);
  assign empty_o = n_q == '0;
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      n_q  <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      n_q  <= n_d;
    end
  end
endmodule

// File: rtl/vr_vc_converter.sv
// vr_vc_converter: valid/ready to valid/credit bridge with input buffer and saturating credit counter.
// Define VR_VC_CREDIT_ERR_EN to add err_o, a sticky credit-overflow flag.
module vr_vc_converter import vr_vc_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CREDIT_NUM = DEF_CREDIT_NUM,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
`ifdef VR_VC_CREDIT_ERR_EN
  output logic                  err_o,
`endif
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_credit_i
);
  localparam int CW = cnt_width(CREDIT_NUM);
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_NUM);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, head;
  logic valid_q, valid_d, full, empty, push, pop;
  vr_vc_converter_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .data_i (s_data_i),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );
  assign s_ready_o = !full;
  assign push      = s_valid_i && !full;
  assign pop       = !empty && cnt_q != '0;
  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;
  always_comb begin
    cnt_d   = pop && !m_credit_i ? cnt_q - 1'b1 :
              m_credit_i && !pop && cnt_q != CMAX ? cnt_q + 1'b1 : cnt_q;
    valid_d = pop;
    data_d  = pop ? head : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= CMAX;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
`ifdef VR_VC_CREDIT_ERR_EN
  logic err_q, err_d;
  assign err_o = err_q;
  // Overflow: a credit arrives while already holding every credit and nothing is spent.
  always_comb err_d = err_q || (m_credit_i && !pop && cnt_q == CMAX);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  end
`endif
endmodule

// File: tb/tb_vr_vc_converter.sv
// tb_vr_vc_converter: randomized + directed scoreboard bench against a queue-level reference model.
module tb_vr_vc_converter;
  localparam int DW = 8;
  localparam int CN = 2;
  localparam int BD = 2;
  logic clk = 0, rst_n = 0;
  logic [DW-1:0] s_data_i = '0, m_data_o;
  logic s_valid_i = 0, s_ready_o, m_valid_o, m_credit_i = 0;
`ifdef VR_VC_CREDIT_ERR_EN
  logic err_o;
`endif
  int total = 0, passed = 0;
  vr_vc_converter #(.DATA_WIDTH(DW), .CREDIT_NUM(CN), .BUF_DEPTH(BD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
`ifdef VR_VC_CREDIT_ERR_EN
    .err_o     (err_o),
`endif
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_credit_i(m_credit_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // Reference model: buffered beats, expected output beats, credit count, error flag.
  logic [DW-1:0] mb[$];
  logic [DW-1:0] eq[$];
  int mc = CN;
  bit ev = 0, me = 0, mp, ma;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb.delete();
      eq.delete();
      mc = CN;
      ev = 0;
      me = 0;
    end else begin
      mp = mb.size() > 0 && mc > 0;
      ma = s_valid_i && mb.size() < BD;
      if (m_credit_i && !mp && mc == CN) me = 1;
      ev = mp;
      if (mp) eq.push_back(mb.pop_front());
      if (ma) mb.push_back(s_data_i);
      mc = mc - int'(mp) + int'(m_credit_i);
      if (mc > CN) mc = CN;
    end
  end
  int run = 0, maxrun = 0;
  logic [DW-1:0] want;
  always @(negedge clk) begin
    chk("m_valid_o", int'(m_valid_o), int'(ev));
    chk("s_ready_o", int'(s_ready_o), int'(mb.size() < BD));
    chk("cnt", int'(dut.cnt_q), mc);
`ifdef VR_VC_CREDIT_ERR_EN
    chk("err_o", int'(err_o), int'(me));
`endif
    if (m_valid_o) begin
      run++;
      if (eq.size() == 0) chk("unexpected beat", int'(m_data_o), -1);
      else begin
        want = eq.pop_front();
        chk("m_data_o", int'(m_data_o), int'(want));
      end
    end else begin
      if (run > maxrun) maxrun = run;
      run = 0;
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic beat(input logic [DW-1:0] d);
    s_valid_i = 1;
    s_data_i  = d;
    cyc();
    s_valid_i = 0;
  endtask
  initial begin
    #3;
    chk("reset m_data_o", int'(m_data_o), 0);
    chk("reset m_valid_o", int'(m_valid_o), 0);
    chk("reset s_ready_o", int'(s_ready_o), 1);
    cyc(2);
    rst_n = 1;
    cyc(2);
    beat(8'hA1);
    beat(8'hA2);
    beat(8'hA3);
    cyc(4);
    chk("held with no credits", int'(dut.cnt_q), 0);
    m_credit_i = 1;
    cyc();
    m_credit_i = 0;
    cyc(3);
    chk("cnt after one credit", int'(dut.cnt_q), 0);
    beat(8'hB1);
    beat(8'hB2);
    s_valid_i = 1;
    s_data_i  = 8'hB3;
    cyc(5);
    s_valid_i = 0;
    chk("full ready", int'(s_ready_o), 0);
    #2;
    rst_n = 0;
    #1;
    chk("async m_valid_o", int'(m_valid_o), 0);
    chk("async s_ready_o", int'(s_ready_o), 1);
    chk("async cnt", int'(dut.cnt_q), CN);
    cyc(2);
    rst_n = 1;
    cyc(4);
    m_credit_i = 1;
    cyc();
    m_credit_i = 0;
    cyc(2);
    chk("overflow saturates", int'(dut.cnt_q), CN);
`ifdef VR_VC_CREDIT_ERR_EN
    chk("err sticky", int'(err_o), 1);
`endif
    maxrun = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid_i = 1;
      s_data_i  = DW'(i);
      cyc();
      m_credit_i = 1;
    end
    s_valid_i = 0;
    cyc(4);
    m_credit_i = 0;
    cyc(2);
    chk("throughput run", maxrun, 16);
    for (int i = 0; i < 3000; i++) begin
      s_valid_i  = 1'($urandom_range(0, 1));
      s_data_i   = DW'($urandom);
      m_credit_i = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst_n = 0;
        #2;
        rst_n = 1;
      end
      cyc();
    end
    s_valid_i = 0;
    m_credit_i = 1;
    cyc(6);
    m_credit_i = 0;
    cyc(2);
    chk("drained", eq.size() + mb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end
endmodule

// File: doc/vr_vc_converter.md
VR_VC_CONVERTER -- requirements
Module: vr_vc_converter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter CREDIT_NUM, default 2, initial credits, equal to the downstream receiver buffer depth; legal range 1..255.
REQ-003 SHALL have parameter BUF_DEPTH, default 2, depth of the input buffer in entries; legal range 1..16.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_data_i  input  DATA_WIDTH  upstream valid/ready payload.
REQ-007 s_valid_i  input  1  upstream beat valid.
REQ-008 s_ready_o  output  1  upstream ready; beat transfers on an edge where s_valid_i && s_ready_o.
REQ-009 m_data_o  output  DATA_WIDTH  downstream valid/credit payload, registered.
REQ-010 m_valid_o  output  1  downstream beat; each cycle high transfers exactly one beat, registered.
REQ-011 m_credit_i  input  1  downstream credit return; each cycle high returns exactly one credit.

Function
REQ-012 Credit counter cnt SHALL be $clog2(CREDIT_NUM+1) bits wide and hold CREDIT_NUM out of reset.
REQ-013 s_ready_o SHALL equal !buffer_full, combinational from state only, never from s_valid_i.
REQ-014 An accepted upstream beat SHALL be written to the input buffer in arrival order.
REQ-015 On each edge where buffer is non-empty and cnt != 0, the head entry SHALL be popped, registered into m_data_o, and m_valid_o SHALL be 1 for the following cycle.
REQ-016 m_valid_o SHALL be 0 in any cycle following an edge without a pop; m_data_o SHALL hold its last value when m_valid_o is 0.
REQ-017 Minimum latency: beat accepted on edge k SHALL appear on m_valid_o in the cycle after edge k+1; no bypass path from s_data_i to m_data_o.
REQ-018 Sustained throughput SHALL be one beat per cycle when credits are available and the buffer is non-empty.
REQ-019 cnt update per edge: pop only -> cnt-1; m_credit_i only -> cnt+1; pop and m_credit_i together -> unchanged; neither -> unchanged.
REQ-020 cnt = 0 SHALL block pops; a credit returned on edge k SHALL allow a pop on edge k+1, not on edge k.
REQ-021 m_credit_i while cnt == CREDIT_NUM and no pop (overflow) SHALL saturate cnt at CREDIT_NUM.
REQ-022 Simultaneous upstream push and pop on a full buffer SHALL NOT occur, because s_ready_o is 0 when full; a push and pop on a non-full buffer SHALL both take effect.
REQ-023 Beat order end-to-end SHALL be preserved; no beat SHALL be dropped or duplicated.

Reset
REQ-024 Reset values SHALL be: s_ready_o = 1, m_valid_o = 0, m_data_o = 0, cnt = CREDIT_NUM, buffer empty.
REQ-025 Reset asserted mid-transfer SHALL discard buffered beats and restore full credits immediately, without waiting for a clock.
REQ-026 Credits in flight at reset are the receiver's responsibility; the receiver resets in the same domain.

Configuration
REQ-027 Macro VR_VC_CREDIT_ERR_EN SHALL, when defined, add output err_o (1 bit), a sticky flag set on the edge after any overflow (REQ-021) and cleared only by reset (reset value 0).
REQ-028 Without VR_VC_CREDIT_ERR_EN, port err_o and its logic SHALL be absent, and overflow SHALL only saturate.

Structure
REQ-029 Package vr_vc_pkg SHALL hold the default constants (DATA_WIDTH, CREDIT_NUM, BUF_DEPTH) and the credit-counter width function.
REQ-030 Input buffer SHALL be the existing sub-module fifo (push/pop/data/full/empty, asynchronous active-low reset), instantiated with DEPTH = BUF_DEPTH.
REQ-031 Credit counter, output register and error flag SHALL be local to vr_vc_converter.

Verification
REQ-032 Reset, CREDIT_NUM=2, then send beats 0xA1, 0xA2, 0xA3 with no m_credit_i -> 0xA1 and 0xA2 on m_valid_o two cycles after acceptance; 0xA3 held; s_ready_o stays 1 (one entry used).
REQ-033 Continuing REQ-032, pulse m_credit_i once -> 0xA3 appears on m_valid_o in the cycle after the edge following the credit; cnt ends at 0.
REQ-034 CREDIT_NUM=4, BUF_DEPTH=2, m_credit_i tied 1 after the first beat, 16 back-to-back beats 0x00..0x0F -> 16 consecutive m_valid_o cycles in order; cnt stays at 3 in steady state.
REQ-035 cnt=0, buffer filled to 2 entries -> s_ready_o=0, s_valid_i held high for 5 cycles -> no acceptance, no m_valid_o.
REQ-036 Idle with cnt=CREDIT_NUM, pulse m_credit_i -> cnt stays CREDIT_NUM; with VR_VC_CREDIT_ERR_EN, err_o=1 from the next cycle until rst_n.
REQ-037 Assert rst_n=0 asynchronously with 2 beats buffered and cnt=0 -> m_valid_o=0, s_ready_o=1, cnt=CREDIT_NUM immediately; after release, no stale beat is emitted.
